// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes, functs and
// datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StExec    = 4'd2,
        StAluWb   = 4'd3,
        StMemAddr = 4'd4,
        StMemRd   = 4'd5,
        StMemWr   = 4'd6,
        StMemWb   = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StJalWb   = 4'd10,
        StJr      = 4'd11,
        StTrap    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_PASS = 3'b111;

    localparam logic [1:0] EXT_SIGN  = 2'b00;
    localparam logic [1:0] EXT_ZERO  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] WSRC_ALU = 2'b00;
    localparam logic [1:0] WSRC_MDR = 2'b01;
    localparam logic [1:0] WSRC_PC  = 2'b10;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    // States that wait on mem_ready and may time out.
    function automatic logic is_mem_state(state_t s);
        return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control-unit port bundle: instruction fields and memory handshake in, datapath controls out.
interface mc_ctrl_fsm_if #(
    parameter int unsigned ALU_W = 3
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             mem_ready;
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic             branch;
    logic             branch_ne;
    logic [1:0]       pc_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [ALU_W-1:0] alu_control;
    logic [1:0]       ext_mode;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic             reg_write;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [3:0]       state_o;

    modport master (
        input  op, funct, mem_ready,
        output mem_read, mem_write, iord, ir_write, pc_write, branch, branch_ne, pc_src,
               alu_src_a, alu_src_b, alu_control, ext_mode, reg_dst, mem_to_reg, reg_write,
               trap, trap_cause, state_o
    );

    modport slave (
        output op, funct, mem_ready,
        input  mem_read, mem_write, iord, ir_write, pc_write, branch, branch_ne, pc_src,
               alu_src_a, alu_src_b, alu_control, ext_mode, reg_dst, mem_to_reg, reg_write,
               trap, trap_cause, state_o
    );
endinterface

// File: rtl/mc_alu_decode.sv
// Combinational op/funct decode to ALU operation, immediate extension and B source,
// plus a legality flag for the ALU-class instructions.
module mc_alu_decode
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ALU_W = 3
) (
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    output logic [ALU_W-1:0] alu_control,
    output logic [1:0]       ext_mode,
    output logic [1:0]       alu_src_b,
    output logic             legal
);
    logic [2:0] alu_code;

    always_comb begin
        alu_code  = ALU_ADD;
        ext_mode  = EXT_SIGN;
        alu_src_b = SRCB_IMM;
        legal     = 1'b1;
        if (op == OP_RTYPE) begin
            alu_src_b = SRCB_RT;
            case (funct)
                FN_ADD, FN_ADDU: alu_code = ALU_ADD;
                FN_SUB:          alu_code = ALU_SUB;
                FN_AND:          alu_code = ALU_AND;
                FN_OR:           alu_code = ALU_OR;
                FN_SLT:          alu_code = ALU_SLT;
                default:         legal    = 1'b0;
            endcase
        end else begin
            case (op)
                OP_ADDI, OP_ADDIU: alu_code = ALU_ADD;
                OP_SLTI:           alu_code = ALU_SLT;
                OP_ANDI: begin
                    alu_code = ALU_AND;
                    ext_mode = EXT_ZERO;
                end
                OP_ORI: begin
                    alu_code = ALU_OR;
                    ext_mode = EXT_ZERO;
                end
                OP_LUI: begin
                    alu_code = ALU_ADD;
                    ext_mode = EXT_UPPER;
                end
                default: legal = 1'b0;
            endcase
        end
    end

    assign alu_control = ALU_W'(alu_code);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM with memory wait handshake, timeout and sticky trap.
// Controls are combinational from state, op, funct and mem_ready.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ALU_W    = 3,
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned WAIT_EN  = 1
) (
    input  logic          clk,
    input  logic          rst,
    mc_ctrl_fsm_if.master bus
);
    localparam logic [7:0] WaitLimit = 8'(WAIT_MAX);

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [1:0]       cause_q, cause_d;
    logic             ready;
    logic             dec_legal;
    logic [ALU_W-1:0] dec_alu;
    logic [1:0]       dec_ext;
    logic [1:0]       dec_srcb;

    mc_alu_decode #(
        .ALU_W(ALU_W)
    ) u_alu_decode (
        .op          (bus.op),
        .funct       (bus.funct),
        .alu_control (dec_alu),
        .ext_mode    (dec_ext),
        .alu_src_b   (dec_srcb),
        .legal       (dec_legal)
    );

    assign ready = (WAIT_EN != 0) ? bus.mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFetch;
            wait_q  <= '0;
            cause_q <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.iord        = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.branch      = 1'b0;
        bus.branch_ne   = 1'b0;
        bus.pc_src      = PCSRC_ALU;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = SRCB_RT;
        bus.alu_control = '0;
        bus.ext_mode    = EXT_SIGN;
        bus.reg_dst     = REGDST_RT;
        bus.mem_to_reg  = WSRC_ALU;
        bus.reg_write   = 1'b0;
        state_d         = state_q;
        wait_d          = '0;
        cause_d         = cause_q;

        case (state_q)
            StFetch: begin
                bus.mem_read    = 1'b1;
                bus.alu_src_b   = SRCB_FOUR;
                bus.alu_control = ALU_W'(ALU_ADD);
                bus.ir_write    = ready;
                bus.pc_write    = ready;
                state_d         = StDecode;
            end
            StDecode: begin
                bus.alu_src_b   = SRCB_IMM_SH;
                bus.alu_control = ALU_W'(ALU_ADD);
                if (bus.op == OP_BEQ || bus.op == OP_BNE) begin
                    state_d = StBranch;
                end else if (bus.op == OP_J) begin
                    state_d = StJump;
                end else if (bus.op == OP_JAL) begin
                    state_d = StJalWb;
                end else if (bus.op == OP_LW || bus.op == OP_SW) begin
                    state_d = StMemAddr;
                end else if (bus.op == OP_RTYPE && bus.funct == FN_JR) begin
                    state_d = StJr;
                end else if (dec_legal) begin
                    state_d = StExec;
                end else begin
                    state_d = StTrap;
                    cause_d = TRAP_ILLEGAL;
                end
            end
            StExec: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = dec_srcb;
                bus.alu_control = dec_alu;
                bus.ext_mode    = dec_ext;
                state_d         = StAluWb;
            end
            StAluWb: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = (bus.op == OP_RTYPE) ? REGDST_RD : REGDST_RT;
                state_d       = StFetch;
            end
            StMemAddr: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = SRCB_IMM;
                bus.alu_control = ALU_W'(ALU_ADD);
                state_d         = (bus.op == OP_LW) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                bus.iord     = 1'b1;
                bus.mem_read = 1'b1;
                state_d      = StMemWb;
            end
            StMemWr: begin
                bus.iord      = 1'b1;
                bus.mem_write = 1'b1;
                state_d       = StFetch;
            end
            StMemWb: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = WSRC_MDR;
                state_d        = StFetch;
            end
            StBranch: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = ALU_W'(ALU_SUB);
                bus.branch      = 1'b1;
                bus.branch_ne   = (bus.op == OP_BNE);
                bus.pc_src      = PCSRC_ALUOUT;
                state_d         = StFetch;
            end
            StJump: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = PCSRC_JUMP;
                state_d      = StFetch;
            end
            StJalWb: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = REGDST_RA;
                bus.mem_to_reg = WSRC_PC;
                bus.pc_write   = 1'b1;
                bus.pc_src     = PCSRC_JUMP;
                state_d        = StFetch;
            end
            StJr: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = PCSRC_RS;
                state_d      = StFetch;
            end
            StTrap: state_d = StTrap;
            default: state_d = StFetch;
        endcase

        // A stalled access overrides the completion target chosen above.
        if (is_mem_state(state_q) && !ready) begin
            if (wait_q == WaitLimit) begin
                state_d = StTrap;
                cause_d = TRAP_TIMEOUT;
            end else begin
                state_d = state_q;
                wait_d  = wait_q + 8'd1;
            end
        end
    end

    assign bus.trap       = (state_q == StTrap);
    assign bus.trap_cause = cause_q;
    assign bus.state_o    = state_q;

endmodule
